// File: rtl/dcache_ctrl.sv
// Sequencing controller for a 2-way set-associative write-back data cache:
// hit detection, store merge, and write-back/refill sequencing against a 256-bit memory port.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MISS      = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    FILLWR    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [24:0]   victim_tag_q, victim_tag_d;
  logic [255:0]  victim_data_q, victim_data_d;
  logic [255:0]  fill_data_q, fill_data_d;

  logic [22:0]   addr_tag;
  logic [3:0]    addr_index;
  logic [2:0]    addr_word;
  logic [255:0]  merge_line;
  logic [31:0]   read_word;

  assign addr_tag   = cpu_addr_i[31:9];
  assign addr_index = cpu_addr_i[8:5];
  assign addr_word  = cpu_addr_i[4:2];
  assign read_word  = sram_data_i[{addr_word, 5'b0} +: 32];

  // Store merge: the addressed word slot takes the CPU data, the rest keep the hit line.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merge_line[32*gi +: 32] = (addr_word == 3'(gi)) ? cpu_data_i
                                                             : sram_data_i[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      fill_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      victim_tag_q  <= victim_tag_d;
      victim_data_q <= victim_data_d;
      fill_data_q   <= fill_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_tag_d  = victim_tag_q;
    victim_data_d = victim_data_q;
    fill_data_d   = fill_data_q;
    cpu_data_o    = '0;
    sram_addr_o   = addr_index;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    sram_enable_o = 1'b1;
    sram_write_o  = 1'b0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;

    case (state_q)
      IDLE: begin
        sram_enable_o = cpu_req_i;
        if (cpu_req_i) begin
          if (sram_hit_i) begin
            if (cpu_write_i) begin
              sram_write_o = 1'b1;
              sram_data_o  = merge_line;
              sram_tag_o   = {2'b11, addr_tag};
            end else begin
              cpu_data_o = read_word;
            end
          end else begin
            state_d = MISS;
          end
        end
      end
      MISS: begin
        victim_tag_d  = sram_tag_i;
        victim_data_d = sram_data_i;
        state_d       = (sram_tag_i[24] && sram_tag_i[23]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag_q[22:0], addr_index, 5'b0};
        mem_data_o   = victim_data_q;
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {addr_tag, addr_index, 5'b0};
        if (mem_ack_i) begin
          fill_data_d = mem_data_i;
          state_d     = FILLWR;
        end
      end
      FILLWR: begin
        // Installed clean; a pending store dirties it on the following hit cycle.
        sram_write_o = 1'b1;
        sram_data_o  = fill_data_q;
        sram_tag_o   = {2'b10, addr_tag};
        state_d      = IDLE;
      end
      default: begin
        sram_enable_o = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  // Held-off while rst_i is high so an aborted access reads as not stalled.
  assign cpu_stall_o = ~rst_i & cpu_req_i & ((state_q != IDLE) | ~sram_hit_i);

endmodule
